// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, command/reply codes
// and the odd-parity helper used by both the transmit and receive sides.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_state_e;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;

   // Index of the last clock fall that belongs to the frame (the stop bit).
   localparam logic [3:0] FRAME_LAST_FALL = 4'd10;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads, plus a third clock
// flop so a falling edge of the synchronized clock can be detected.
module ps2_sync (
   input  logic clock,
   input  logic reset,
   input  logic io_ps2_clk,
   input  logic io_ps2_data,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fall
);

   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic data_meta_q, data_sync_q;
   logic clk_meta_d, clk_sync_d, clk_prev_d;
   logic data_meta_d, data_sync_d;

   always_comb begin
      clk_meta_d  = io_ps2_clk;
      clk_sync_d  = clk_meta_q;
      clk_prev_d  = clk_sync_q;
      data_meta_d = io_ps2_data;
      data_sync_d = data_meta_q;
   end

   // NOTE: flops reset to 1 (idle bus level) so leaving reset never fakes a fall.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         clk_prev_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= clk_meta_d;
         clk_sync_q  <= clk_sync_d;
         clk_prev_q  <= clk_prev_d;
         data_meta_q <= data_meta_d;
         data_sync_q <= data_sync_d;
      end
   end

   assign clk_sync  = clk_sync_q;
   assign data_sync = data_sync_q;
   assign clk_fall  = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift one byte
// with odd parity and stop on device clock falls, then check the device ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       io_ps2_clk,
   input  logic       io_ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int IW = $clog2(INHIBIT_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   logic clk_sync, data_sync, clk_fall;

   ps2_sync u_sync (
      .clock       (clock),
      .reset       (reset),
      .io_ps2_clk  (io_ps2_clk),
      .io_ps2_data (io_ps2_data),
      .clk_sync    (clk_sync),
      .data_sync   (data_sync),
      .clk_fall    (clk_fall)
   );

   ps2_state_e    state_q, state_d;
   logic [IW-1:0] inh_cnt_q, inh_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [9:0]    shift_q, shift_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   always_comb begin
      state_d   = state_q;
      inh_cnt_d = inh_cnt_q;
      to_cnt_d  = to_cnt_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      ready_d   = ready_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            ready_d   = 1'b1;
            if (tx_valid && ready_q) begin
               shift_d   = {1'b1, odd_parity(tx_data), tx_data};
               bit_idx_d = '0;
               inh_cnt_d = '0;
               clk_oe_d  = 1'b1;
               ready_d   = 1'b0;
               state_d   = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               data_oe_d = 1'b1;
               state_d   = ST_REQ;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end

         ST_REQ: begin
            clk_oe_d = 1'b0;
            to_cnt_d = '0;
            state_d  = ST_SEND;
         end

         ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
            // The timeout wins even if a clock fall arrives in the same cycle.
            if (to_cnt_q == TO_LAST) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
               if (state_q == ST_SEND) begin
                  if (clk_fall) begin
                     data_oe_d = ~shift_q[0];
                     shift_d   = {1'b0, shift_q[9:1]};
                     bit_idx_d = bit_idx_q + 1'b1;
                     if (bit_idx_q == FRAME_LAST_FALL - 4'd1) begin
                        state_d = ST_ACK;
                     end
                  end
               end else if (state_q == ST_ACK) begin
                  data_oe_d = 1'b0;
                  if (clk_fall) begin
                     if (!data_sync) begin
                        state_d = ST_WAIT_IDLE;
                     end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                     end
                  end
               end else if (clk_sync && data_sync) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         inh_cnt_q <= '0;
         to_cnt_q  <= '0;
         shift_q   <= '0;
         bit_idx_q <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         inh_cnt_q <= inh_cnt_d;
         to_cnt_q  <= to_cnt_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_ready    = ready_q;
   assign tx_done     = done_q;
   assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain device model clocks
// frames out of the DUT and checks every line sample against a scoreboard.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 20;
   localparam int TO   = 1500;
   localparam int HALF = 30;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       io_ps2_clk, io_ps2_data;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, tx_done, tx_err;

   assign io_ps2_clk  = dev_clk & ~ps2_clk_oe;
   assign io_ps2_data = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .io_ps2_clk  (io_ps2_clk),
      .io_ps2_data (io_ps2_data),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_err      (tx_err)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int pulse_cyc = 0;
   int ready_rise_cyc = 0;
   logic ready_prev = 1'b1;

   bit exp_bits[$];
   bit exp_ok[$];

   always @(posedge clock) cyc++;

   // Counts high cycles of each pulse and records when tx_ready comes back.
   always @(negedge clock) begin
      if (tx_done) begin
         done_cnt++;
         pulse_cyc = cyc;
      end
      if (tx_err) begin
         err_cnt++;
         pulse_cyc = cyc;
      end
      if (tx_ready && !ready_prev) ready_rise_cyc = cyc;
      ready_prev = tx_ready;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] d, input bit ok);
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
      exp_bits.push_back(~^d);
      exp_bits.push_back(1'b1);
      exp_ok.push_back(ok);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clock);
      while (!tx_ready && n < 3000) begin
         @(negedge clock);
         n++;
      end
      check("ready_wait", tx_ready, 1);
   endtask

   task automatic start_tx(input logic [7:0] d, input bit ok, input bit model);
      wait_ready();
      tx_valid = 1'b1;
      tx_data  = d;
      if (model) push_frame(d, ok);
      @(posedge clock);
      #1;
      tx_valid = 1'b0;
      tx_data  = ~d;
   endtask

   // Device side: clocks 11 slots, samples the line before each fall, then
   // optionally drives ACK low for the 11th fall. abort_fall > 0 stops early.
   task automatic device_frame(input bit ack_low, input int abort_fall);
      int n, d0, e0;
      bit s, e;
      d0 = done_cnt;
      e0 = err_cnt;
      n  = 0;
      while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check("frame_start", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      for (int i = 0; i < 11; i++) begin
         repeat (HALF) @(negedge clock);
         s = io_ps2_data;
         check("sb_underflow", exp_bits.size() > 0, 1);
         e = (exp_bits.size() > 0) ? exp_bits.pop_front() : ~s;
         check($sformatf("slot%0d", i), s, e);
         if (i == 10) break;
         dev_clk = 1'b0;
         if (i + 1 == abort_fall) return;
         repeat (HALF) @(negedge clock);
         dev_clk = 1'b1;
      end
      if (ack_low) dev_data = 1'b0;
      repeat (HALF) @(negedge clock);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < 500) begin
         @(negedge clock);
         n++;
      end
      repeat (3) @(negedge clock);
      e = exp_ok.pop_front();
      check("result_done", done_cnt - d0, {31'd0, e});
      check("result_err", err_cnt - e0, {31'd0, ~e});
   endtask

   initial begin
      int n, t0;

      // Reset values
      repeat (3) @(negedge clock);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_ready", tx_ready, 1);
      check("rst_done", tx_done, 0);
      check("rst_err", tx_err, 0);
      reset = 1'b0;

      // 0xED with inhibit/request timing checked edge by edge
      wait_ready();
      tx_valid = 1'b1;
      tx_data  = CMD_SET_LEDS;
      push_frame(CMD_SET_LEDS, 1'b1);
      @(posedge clock);
      #1;
      tx_valid = 1'b0;
      check("acc_ready", tx_ready, 0);
      check("acc_clk_oe", ps2_clk_oe, 1);
      check("acc_data_oe", ps2_data_oe, 0);
      repeat (INH) @(negedge clock);
      check("inh_end_clk_oe", ps2_clk_oe, 1);
      check("inh_end_data_oe", ps2_data_oe, 0);
      @(negedge clock);
      check("req_clk_oe", ps2_clk_oe, 1);
      check("req_data_oe", ps2_data_oe, 1);
      @(negedge clock);
      check("send_clk_oe", ps2_clk_oe, 0);
      check("send_data_oe", ps2_data_oe, 1);
      device_frame(1'b1, 0);
      wait_ready();
      check("done_ready_lag", ready_rise_cyc - pulse_cyc, 1);

      // Parity slot low for 0x01, released for 0x00
      start_tx(8'h01, 1'b1, 1'b1);
      device_frame(1'b1, 0);
      start_tx(8'h00, 1'b1, 1'b1);
      device_frame(1'b1, 0);

      // NAK: device leaves data high in the ACK slot
      start_tx(CMD_ENABLE, 1'b0, 1'b1);
      device_frame(1'b0, 0);
      wait_ready();
      check("nak_ready_lag", ready_rise_cyc - pulse_cyc, 1);
      check("nak_clk_oe", ps2_clk_oe, 0);
      check("nak_data_oe", ps2_data_oe, 0);

      // Timeout: device never clocks
      start_tx(CMD_SET_LEDS, 1'b0, 1'b0);
      n = 0;
      while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 2000) begin
         @(negedge clock);
         n++;
      end
      t0 = cyc;
      n  = 0;
      while (!tx_err && n < TO + 100) begin
         @(negedge clock);
         n++;
      end
      check("to_err", tx_err, 1);
      check("to_cycles", cyc - t0, TO);
      check("to_clk_oe", ps2_clk_oe, 0);
      check("to_data_oe", ps2_data_oe, 0);

      // Reset while bit 4 (a 0) is on the line
      start_tx(8'h45, 1'b1, 1'b1);
      device_frame(1'b1, 5);
      repeat (10) @(negedge clock);
      check("mid_data_oe", ps2_data_oe, 1);
      #2 reset = 1'b1;
      #1;
      check("arst_clk_oe", ps2_clk_oe, 0);
      check("arst_data_oe", ps2_data_oe, 0);
      check("arst_ready", tx_ready, 1);
      exp_bits.delete();
      exp_ok.delete();
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      start_tx(CMD_RESET, 1'b1, 1'b1);
      device_frame(1'b1, 0);

      // tx_valid held high with changing tx_data during a transfer
      wait_ready();
      tx_valid = 1'b1;
      tx_data  = 8'h12;
      push_frame(8'h12, 1'b1);
      @(posedge clock);
      #1;
      tx_data = 8'h34;
      check("hold_ready_low", tx_ready, 0);
      device_frame(1'b1, 0);
      wait_ready();
      push_frame(8'h34, 1'b1);
      @(posedge clock);
      #1;
      tx_valid = 1'b0;
      check("hold2_ready_low", tx_ready, 0);
      device_frame(1'b1, 0);

      wait_ready();
      check("sb_bits_drained", exp_bits.size(), 0);
      check("sb_ok_drained", exp_ok.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the send side of the keyboard link that `ps2_keyboard` only receives. It accepts one command byte per handshake and runs the inhibit/request-to-send sequence. It then shifts the byte out LSB first, with odd parity and a stop bit, on device-generated clock edges, and checks the device's acknowledge bit. Typical commands are 0xED (set LEDs) and 0xFF (reset). It sits beside `ps2_keyboard` on the same `io_ps2_clk`/`io_ps2_data` pads and drives them open-drain.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-line pull-down length in system clocks (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum time from clock-line release to completion (15 ms at 50 MHz).
- `clock`  in  1  system clock; the single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `io_ps2_clk`  in  1  raw PS/2 clock pad value (asynchronous).
- `io_ps2_data`  in  1  raw PS/2 data pad value (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull the PS/2 clock line low; 0 = release.
- `ps2_data_oe`  out  1  1 = pull the PS/2 data line low; 0 = release.
- `tx_valid`  in  1  command byte is available.
- `tx_data`  in  8  command byte.
- `tx_ready`  out  1  high only in IDLE; a transfer is accepted on `tx_valid && tx_ready`.
- `tx_done`  out  1  one-cycle pulse: the device acknowledged the byte.
- `tx_err`  out  1  one-cycle pulse: NAK or timeout.

## Operation
- Both pad inputs pass through a 2-flop synchronizer. A third flop gives edge detection.
- `fall` = previous synchronized clock was 1 and current is 0.
- Parity bit = ~^tx_data (odd parity).
- The shift register is loaded on accept and holds {1'b1 stop, parity, tx_data}. Bit index is a 4-bit counter, 0..10.
- The data line is driven low for a 0 and released for a 1, i.e. `ps2_data_oe = ~bit`.
- FSM states and behaviour:
  - IDLE: both oe = 0, `tx_ready` = 1. On accept, latch the byte and go to INHIBIT.
  - INHIBIT: `ps2_clk_oe` = 1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ (1 cycle): `ps2_clk_oe` = 1 and `ps2_data_oe` = 1 (start bit). Go to SEND, clearing the timeout counter.
  - SEND: `ps2_clk_oe` = 0. `ps2_data_oe` presents the current bit.
    - Initially it holds 1 (start bit low).
    - On falls 1..8 it presents data bits 0..7. On fall 9 it presents parity. On fall 10 it presents the stop bit, i.e. it releases.
    - After fall 10, go to ACK.
  - ACK: both oe = 0. On the next `fall`, sample synchronized data.
    - Data 0: go to WAIT_IDLE.
    - Data 1: pulse `tx_err` and go to IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse `tx_done` and go to IDLE.
- Timeout counter:
  - Runs in SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces both oe = 0, pulses `tx_err` and returns to IDLE.
  - The timeout takes precedence over a coincident `fall`.
- `tx_valid` is ignored outside IDLE, and `tx_data` is not re-sampled mid-transfer.
- Counter widths are $clog2 of the respective parameter. INHIBIT_CYCLES and TIMEOUT_CYCLES must be ≥ 2.

## Timing
- Reset values: `ps2_clk_oe` = 0, `ps2_data_oe` = 0, `tx_ready` = 1, `tx_done` = 0, `tx_err` = 0, state IDLE, all counters 0.
- Asserting reset mid-transfer releases both lines asynchronously.
- Accept at edge N:
  - `tx_ready` falls at N.
  - `ps2_clk_oe` rises at N.
  - `ps2_data_oe` rises at N+INHIBIT_CYCLES.
  - `ps2_clk_oe` falls at N+INHIBIT_CYCLES+1.
- Edge-detect latency: `fall` is seen 3 clocks after the pad edge. `ps2_data_oe` updates on the cycle after `fall`.
- Each output pulse is exactly 1 cycle. `tx_ready` returns high in the cycle after the `tx_done`/`tx_err` pulse.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `ps2_pkg` holds:
  - the FSM state encoding (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE);
  - command constants 0xED, 0xF4, 0xFF and device replies 0xFA and 0xFE;
  - the odd-parity function, shared with `ps2_keyboard`.
- Sub-module `ps2_sync`: 2-flop synchronizer plus falling-edge detect for `io_ps2_clk`, with a synchronized pass-through for `io_ps2_data`. It is reused by `ps2_keyboard`.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and driving ACK low → data line shows 0,1,0,1,1,0,1,1,1 (start, bits LSB first), then parity 1, then stop released. `tx_done` pulses once and `tx_err` stays 0.
- Send 0x01 (parity 0) and 0x00 (parity 1) → the parity slot drives low, then released, respectively.
- Device leaves data high in the ACK slot → one `tx_err` pulse, no `tx_done`, return to IDLE with both oe = 0.
- Device never clocks after REQ → `tx_err` exactly TIMEOUT_CYCLES after clock release, both lines released.
- Assert reset during bit 4 → both oe = 0 immediately, `tx_ready` = 1. A subsequent 0xFF send completes normally.
- Hold `tx_valid` high with changing `tx_data` during a transfer → only the first byte is sent. The second is accepted only after `tx_ready` returns high.
